// File: rtl/dram_refresh_scheduler_if.sv
// Handshake and status bundle between the refresh scheduler and the RAS/CAS sequencer.
// The scheduler uses the master modport; the sequencer side (or a bench) uses slave.
interface dram_refresh_scheduler_if;
   logic       ASn;
   logic       RAM_BUSY;
   logic       REFRESH_ACK;
   logic       REFRESH_REQ;
   logic       URGENT;
   logic       INIT_DONE;
   logic [2:0] PENDING;
   logic       OVERRUN;

   modport master (
      input  ASn, RAM_BUSY, REFRESH_ACK,
      output REFRESH_REQ, URGENT, INIT_DONE, PENDING, OVERRUN
   );

   modport slave (
      output ASn, RAM_BUSY, REFRESH_ACK,
      input  REFRESH_REQ, URGENT, INIT_DONE, PENDING, OVERRUN
   );
endinterface

// File: rtl/dram_refresh_scheduler.sv
// DRAM power-up sequencing and refresh-debt arbitration ahead of the RAS/CAS sequencer.
// Optional macro REFRESH_URGENT_EN: a saturated debt may request refresh during bus cycles.
module dram_refresh_scheduler #(
   parameter int unsigned INIT_CYCLES      = 1420,
   parameter int unsigned INIT_REFRESHES   = 8,
   parameter int unsigned REFRESH_INTERVAL = 110,
   parameter int unsigned MAX_PENDING      = 4
) (
   input  logic                     CLK,
   input  logic                     RESET,
   dram_refresh_scheduler_if.master bus
);

   // The debt counter must hold the initial refresh burst as well as the run-time limit.
   localparam int unsigned DEBT_TOP = (INIT_REFRESHES > MAX_PENDING) ? INIT_REFRESHES : MAX_PENDING;
   localparam int unsigned WAIT_W   = $clog2(INIT_CYCLES + 1);
   localparam int unsigned INTV_W   = $clog2(REFRESH_INTERVAL + 1);
   localparam int unsigned INIT_W   = $clog2(INIT_REFRESHES + 1);
   localparam int unsigned DEBT_W   = $clog2(DEBT_TOP + 1);

   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(INIT_CYCLES - 1);
   localparam logic [INTV_W-1:0] INTV_LOAD = INTV_W'(REFRESH_INTERVAL - 1);
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_REFRESHES - 1);
   localparam logic [DEBT_W-1:0] DEBT_INIT = DEBT_W'(INIT_REFRESHES);
   localparam logic [DEBT_W-1:0] DEBT_MAX  = DEBT_W'(MAX_PENDING);
   localparam logic [DEBT_W-1:0] DEBT_ONE  = DEBT_W'(1);

   typedef enum logic [1:0] {
      INIT_WAIT    = 2'd0,
      INIT_REFRESH = 2'd1,
      RUN          = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [INTV_W-1:0] intv_q, intv_d;
   logic [INIT_W-1:0] init_q, init_d;
   logic [DEBT_W-1:0] debt_q, debt_d;
   logic              req_q, req_d;
   logic              done_q, done_d;
   logic              ovr_q, ovr_d;
   logic              urgent_q;
   logic [2:0]        pend_q;
   logic              as_meta_q, as_sync_q;

   logic bus_idle_s, req_ok_s, tick_s, ack_ok_s;

   // The debt can exceed 7 only during the power-up burst; the 3-bit port shows it clipped.
   function automatic logic [2:0] clip_pending(input logic [DEBT_W-1:0] d);
      logic [DEBT_W+2:0] wide;
      wide = {3'b000, d};
      if (wide > (DEBT_W + 3)'(7)) begin
         return 3'd7;
      end else begin
         return wide[2:0];
      end
   endfunction

   assign bus_idle_s = as_sync_q & ~bus.RAM_BUSY;
`ifdef REFRESH_URGENT_EN
   assign req_ok_s   = bus_idle_s | (urgent_q & ~bus.RAM_BUSY);
`else
   assign req_ok_s   = bus_idle_s;
`endif
   assign tick_s     = (state_q == RUN) && (intv_q == INTV_W'(0));
   assign ack_ok_s   = bus.REFRESH_ACK & req_q & (debt_q != DEBT_W'(0));

   // Two-flop synchroniser for the asynchronous address strobe.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         as_meta_q <= 1'b1;
         as_sync_q <= 1'b1;
      end else begin
         as_meta_q <= bus.ASn;
         as_sync_q <= as_meta_q;
      end
   end

   // Next-state logic: power-up sequencing, debt arithmetic and request handshake.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      intv_d  = intv_q;
      init_d  = init_q;
      debt_d  = debt_q;
      done_d  = done_q;
      ovr_d   = ovr_q;
      req_d   = 1'b0;
      case (state_q)
         INIT_WAIT: begin
            if (wait_q == WAIT_W'(0)) begin
               state_d = INIT_REFRESH;
               debt_d  = DEBT_INIT;
            end else begin
               wait_d = wait_q - WAIT_W'(1);
            end
         end
         INIT_REFRESH, RUN: begin
            case ({tick_s, ack_ok_s})
               2'b10: begin
                  if (debt_q == DEBT_MAX) begin
                     ovr_d = 1'b1;
                  end else begin
                     debt_d = debt_q + DEBT_ONE;
                  end
               end
               2'b01:   debt_d = debt_q - DEBT_ONE;
               default: debt_d = debt_q;
            endcase
            if (state_q == RUN) begin
               intv_d = tick_s ? INTV_LOAD : (intv_q - INTV_W'(1));
            end else if (ack_ok_s) begin
               init_d = init_q + INIT_W'(1);
               if (init_q == INIT_LAST) begin
                  state_d = RUN;
                  done_d  = 1'b1;
                  intv_d  = INTV_LOAD;
               end else begin
                  state_d = INIT_REFRESH;
               end
            end else begin
               init_d = init_q;
            end
            // An outstanding request is never withdrawn before its acknowledge.
            if (req_q && !ack_ok_s) begin
               req_d = 1'b1;
            end else begin
               req_d = (debt_d != DEBT_W'(0)) && req_ok_s;
            end
         end
         default: begin
            state_d = INIT_WAIT;
            wait_d  = WAIT_LOAD;
            intv_d  = INTV_LOAD;
            init_d  = INIT_W'(0);
            debt_d  = DEBT_W'(0);
            done_d  = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= INIT_WAIT;
         wait_q   <= WAIT_LOAD;
         intv_q   <= INTV_LOAD;
         init_q   <= INIT_W'(0);
         debt_q   <= DEBT_W'(0);
         req_q    <= 1'b0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
         urgent_q <= 1'b0;
         pend_q   <= 3'd0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         intv_q   <= intv_d;
         init_q   <= init_d;
         debt_q   <= debt_d;
         req_q    <= req_d;
         done_q   <= done_d;
         ovr_q    <= ovr_d;
         urgent_q <= (debt_d == DEBT_MAX);
         pend_q   <= clip_pending(debt_d);
      end
   end

   assign bus.REFRESH_REQ = req_q;
   assign bus.URGENT      = urgent_q;
   assign bus.INIT_DONE   = done_q;
   assign bus.PENDING     = pend_q;
   assign bus.OVERRUN     = ovr_q;

endmodule

// File: tb/tb_dram_refresh_scheduler.sv
// Self-checking bench for dram_refresh_scheduler: directed scenarios plus randomized
// traffic, all checked against a cycle-level behavioural model of the refresh rules.
module tb_dram_refresh_scheduler;

   localparam int INIT_CYCLES = 20;
   localparam int INIT_REFS   = 8;
   localparam int INTERVAL    = 10;
   localparam int MAXP        = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic asn = 1'b1;
   logic busy = 1'b0;
   logic ack = 1'b0;
   bit   auto_ack = 1'b0;
   int   hs = 0;
   int   npass = 0;
   int   ntotal = 0;

   dram_refresh_scheduler_if ifc ();
   assign ifc.ASn         = asn;
   assign ifc.RAM_BUSY    = busy;
   assign ifc.REFRESH_ACK = ack;

   dram_refresh_scheduler #(
      .INIT_CYCLES      (INIT_CYCLES),
      .INIT_REFRESHES   (INIT_REFS),
      .REFRESH_INTERVAL (INTERVAL),
      .MAX_PENDING      (MAXP)
   ) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   // Reference model: phase 0 = settle wait, 1 = initial refreshes, 2 = running.
   int m_phase, m_wait, m_run, m_debt, m_acks;
   bit m_req, m_urg, m_done, m_ovr, m_s1, m_s2;

   function automatic void model_update(bit r, bit a, bit b, bit k);
      bit idle, ok, tick, ackv;
      if (r) begin
         m_phase = 0; m_wait = 0; m_run = 0; m_debt = 0; m_acks = 0;
         m_req = 0; m_urg = 0; m_done = 0; m_ovr = 0; m_s1 = 1; m_s2 = 1;
         return;
      end
      idle = m_s2 && !b;
      ok   = idle;
`ifdef REFRESH_URGENT_EN
      ok   = idle || (m_urg && !b);
`endif
      if (m_phase == 0) begin
         if (m_wait == INIT_CYCLES - 1) begin
            m_phase = 1;
            m_debt  = INIT_REFS;
         end else begin
            m_wait++;
         end
      end else begin
         tick = (m_phase == 2) && (m_run % INTERVAL == INTERVAL - 1);
         ackv = k && m_req && (m_debt > 0);
         if (tick && !ackv) begin
            if (m_debt == MAXP) m_ovr = 1;
            else m_debt++;
         end else if (ackv && !tick) begin
            m_debt--;
         end
         if (m_phase == 2) m_run++;
         if (m_phase == 1 && ackv) begin
            m_acks++;
            if (m_acks == INIT_REFS) begin
               m_phase = 2;
               m_done  = 1;
               m_run   = 0;
            end
         end
         m_req = (m_req && !ackv) ? 1'b1 : ((m_debt > 0) && ok);
      end
      m_urg = (m_debt == MAXP);
      m_s2  = m_s1;
      m_s1  = a;
   endfunction

   function automatic logic [6:0] exp_vec();
      logic [2:0] p;
      p = (m_debt > 7) ? 3'd7 : 3'(m_debt);
      return {m_req, m_urg, m_done, p, m_ovr};
   endfunction

   function automatic logic [6:0] dut_vec();
      return {ifc.REFRESH_REQ, ifc.URGENT, ifc.INIT_DONE, ifc.PENDING, ifc.OVERRUN};
   endfunction

   // One clock: capture the inputs the DUT samples, advance model, settle, update auto-ACK.
   task automatic step();
      bit r, a, b, k;
      r = rst; a = asn; b = busy; k = ack;
      @(posedge clk);
      model_update(r, a, b, k);
      #1;
      if (k || !m_req) hs = m_req ? 1 : 0;
      else hs++;
      ack = auto_ack && m_req && (hs == 2);
   endtask

   task automatic test_reset();
      rst = 1'b1; asn = 1'b0; busy = 1'b0; ack = 1'b0; auto_ack = 1'b0;
      step();
      step();
      ntotal++;
      if (dut_vec() !== 7'b0) $display("FAIL reset_outputs: got %b exp %b", dut_vec(), 7'b0);
      else npass++;
      ntotal++;
      if (dut_vec() !== exp_vec()) $display("FAIL reset_model: got %b exp %b", dut_vec(), exp_vec());
      else npass++;
   endtask

   task automatic test_init(input bit do_reset);
      int first_req, nack, cyc;
      auto_ack = 1'b1; asn = 1'b1; busy = 1'b0;
      if (do_reset) begin
         rst = 1'b1; ack = 1'b0;
         step();
         step();
      end
      rst = 1'b0;
      first_req = 0; nack = 0;
      for (cyc = 1; cyc <= 300; cyc++) begin
         if (ack) nack++;
         step();
         ntotal++;
         if (dut_vec() !== exp_vec()) $display("FAIL init_cycle %0d: got %b exp %b", cyc, dut_vec(), exp_vec());
         else npass++;
         if (first_req == 0 && ifc.REFRESH_REQ === 1'b1) first_req = cyc;
         if (ifc.INIT_DONE === 1'b1) break;
      end
      ntotal++;
      if (ifc.INIT_DONE !== 1'b1) $display("FAIL init_done_timeout: got %b exp 1", ifc.INIT_DONE);
      else npass++;
      ntotal++;
      if (first_req != 21) $display("FAIL init_first_req: got cycle %0d exp 21", first_req);
      else npass++;
      ntotal++;
      if (nack != INIT_REFS) $display("FAIL init_ack_count: got %0d exp %0d", nack, INIT_REFS);
      else npass++;
      ntotal++;
      if (ifc.PENDING !== 3'd0) $display("FAIL init_pending: got %0d exp 0", ifc.PENDING);
      else npass++;
   endtask

   task automatic test_run_idle();
      int maxp, rises;
      logic prev;
      auto_ack = 1'b1; asn = 1'b1; busy = 1'b0;
      maxp = 0; rises = 0; prev = ifc.REFRESH_REQ;
      for (int i = 0; i < 1000; i++) begin
         step();
         ntotal++;
         if (dut_vec() !== exp_vec()) $display("FAIL run_idle cyc %0d: got %b exp %b", i, dut_vec(), exp_vec());
         else npass++;
         if (int'(ifc.PENDING) > maxp) maxp = int'(ifc.PENDING);
         if (ifc.REFRESH_REQ === 1'b1 && prev !== 1'b1) rises++;
         prev = ifc.REFRESH_REQ;
      end
      ntotal++;
      if (maxp > 1) $display("FAIL run_idle_max_pending: got %0d exp <=1", maxp);
      else npass++;
      ntotal++;
      if (rises < 99 || rises > 101) $display("FAIL run_idle_req_count: got %0d exp 100", rises);
      else npass++;
      ntotal++;
      if (ifc.OVERRUN !== 1'b0) $display("FAIL run_idle_overrun: got %b exp 0", ifc.OVERRUN);
      else npass++;
   endtask

   task automatic test_saturation();
      int lat, i;
      auto_ack = 1'b1; asn = 1'b0;
      for (i = 0; i < 55; i++) begin
         step();
         ntotal++;
         if (dut_vec() !== exp_vec()) $display("FAIL sat_busy cyc %0d: got %b exp %b", i, dut_vec(), exp_vec());
         else npass++;
      end
`ifndef REFRESH_URGENT_EN
      ntotal++;
      if ({ifc.PENDING, ifc.URGENT, ifc.OVERRUN} !== {3'd4, 1'b1, 1'b1})
         $display("FAIL sat_state: got pend %0d urg %b ovr %b exp 4 1 1", ifc.PENDING, ifc.URGENT, ifc.OVERRUN);
      else npass++;
`endif
      asn = 1'b1;
      lat = 0;
      for (i = 1; i <= 10; i++) begin
         step();
         if (ifc.REFRESH_REQ === 1'b1 && lat == 0) lat = i;
      end
`ifndef REFRESH_URGENT_EN
      ntotal++;
      if (lat != 3) $display("FAIL sat_asn_latency: got %0d exp 3", lat);
      else npass++;
`endif
      for (i = 0; i < 40 && ifc.PENDING !== 3'd0; i++) begin
         step();
         ntotal++;
         if (dut_vec() !== exp_vec()) $display("FAIL sat_drain cyc %0d: got %b exp %b", i, dut_vec(), exp_vec());
         else npass++;
      end
      ntotal++;
      if (ifc.PENDING !== 3'd0 || ifc.OVERRUN !== 1'b1)
         $display("FAIL sat_drained: got pend %0d ovr %b exp 0 1", ifc.PENDING, ifc.OVERRUN);
      else npass++;
   endtask

   task automatic test_tick_ack();
      int i;
      auto_ack = 1'b0; asn = 1'b0;
      for (i = 0; i < 40 && m_debt != 2; i++) step();
      asn = 1'b1;
      for (i = 0; i < 10 && !m_req; i++) step();
      for (i = 0; i < 12 && (m_run % INTERVAL != INTERVAL - 1); i++) step();
      ack = 1'b1;
      step();
      ntotal++;
      if ({ifc.PENDING, ifc.REFRESH_REQ} !== {3'd2, 1'b1})
         $display("FAIL tick_ack: got pend %0d req %b exp 2 1", ifc.PENDING, ifc.REFRESH_REQ);
      else npass++;
      ntotal++;
      if (dut_vec() !== exp_vec()) $display("FAIL tick_ack_model: got %b exp %b", dut_vec(), exp_vec());
      else npass++;
   endtask

   task automatic test_asn_hold();
      auto_ack = 1'b0; asn = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         ntotal++;
         if (ifc.REFRESH_REQ !== 1'b1) $display("FAIL asn_hold cyc %0d: got req %b exp 1", i, ifc.REFRESH_REQ);
         else npass++;
      end
      ack = 1'b1;
      step();
      ntotal++;
      if ({ifc.REFRESH_REQ, ifc.PENDING} !== {1'b0, 3'd1})
         $display("FAIL asn_hold_drop: got req %b pend %0d exp 0 1", ifc.REFRESH_REQ, ifc.PENDING);
      else npass++;
   endtask

   task automatic test_reset_mid();
      auto_ack = 1'b0; asn = 1'b1;
      for (int i = 0; i < 20 && !m_req; i++) step();
      rst = 1'b1;
      step();
      ntotal++;
      if ({ifc.REFRESH_REQ, ifc.INIT_DONE, ifc.PENDING, ifc.OVERRUN} !== 6'b0)
         $display("FAIL reset_mid: got req %b done %b pend %0d ovr %b exp all 0",
                  ifc.REFRESH_REQ, ifc.INIT_DONE, ifc.PENDING, ifc.OVERRUN);
      else npass++;
      test_init(1'b0);
   endtask

   task automatic test_random();
      auto_ack = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(7, 0) == 0) asn = ~asn;
         busy = ($urandom_range(3, 0) == 0);
         ack  = m_req ? ($urandom_range(2, 0) == 0) : ($urandom_range(7, 0) == 0);
         rst  = ($urandom_range(399, 0) == 0);
         step();
         ntotal++;
         if (dut_vec() !== exp_vec()) $display("FAIL random cyc %0d: got %b exp %b", i, dut_vec(), exp_vec());
         else npass++;
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_init(1'b1);
      test_run_idle();
      test_saturation();
      test_tick_ack();
      test_asn_hold();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
